if_id_buffer: RTL and testbench

- Two-entry instruction queue between the fetch stage (PC register, PC+4 adder, instruction ROM) and the decode stage.
- Captures each fetched {pc, instruction} pair. Gives decode a registered, stallable, flushable instruction stream.
- Back-pressures fetch through in_ready. Fetch holds its PC while in_ready is low.
- Feeds a NOP (32'h00000000) to decode whenever no valid entry is held.

---
 rtl/if_id_buffer.sv | 78 +++++++
 tb/tb_if_id_buffer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_buffer.sv
// Two-entry {pc, inst} queue between fetch and decode.
// Outputs come only from registered state; an empty queue presents a NOP.
module if_id_buffer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_inst,
    input  logic [WIDTH-1:0] in_pc,
    output logic             in_ready,
    input  logic             flush,
    input  logic             id_stall,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_inst,
    output logic [WIDTH-1:0] out_pc,
    output logic [1:0]       count,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic [WIDTH-1:0] slotInst [2];
    logic [WIDTH-1:0] slotPc   [2];
    logic             wptr;
    logic             rptr;
    logic [1:0]       countQ;
    logic [CNT_W-1:0] bubbleQ;
    logic             push;
    logic             pop;

    // in_ready depends on occupancy only, so fetch never sees a stall/flush path.
    assign in_ready   = (countQ != 2'd2);
    assign out_valid  = (countQ != 2'd0);
    assign out_inst   = out_valid ? slotInst[rptr] : '0;
    assign out_pc     = out_valid ? slotPc[rptr] : '0;
    assign count      = countQ;
    assign bubble_cnt = bubbleQ;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & ~id_stall & ~flush;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            countQ      <= 2'd0;
            wptr        <= 1'b0;
            rptr        <= 1'b0;
            bubbleQ     <= '0;
            slotInst[0] <= '0;
            slotInst[1] <= '0;
            slotPc[0]   <= '0;
            slotPc[1]   <= '0;
        end else begin
            if (flush) begin
                countQ <= 2'd0;
                wptr   <= 1'b0;
                rptr   <= 1'b0;
            end else begin
                if (push) begin
                    slotInst[wptr] <= in_inst;
                    slotPc[wptr]   <= in_pc;
                    wptr           <= ~wptr;
                end
                if (pop) begin
                    rptr <= ~rptr;
                end
                if (push && !pop) begin
                    countQ <= countQ + 2'd1;
                end else if (pop && !push) begin
                    countQ <= countQ - 2'd1;
                end
            end
            if (!out_valid && (bubbleQ != {CNT_W{1'b1}})) begin
                bubbleQ <= bubbleQ + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: queue scoreboard of expected PCs plus an occupancy
// and bubble model; a second instance with CNT_W=2 covers saturation.
module tb_if_id_buffer;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        id_stall = 1'b0;

    logic        in_ready, out_valid;
    logic [31:0] out_inst, out_pc;
    logic [1:0]  count;
    logic [15:0] bubble_cnt;

    logic        sInReady, sOutValid;
    logic [31:0] sOutInst, sOutPc;
    logic [1:0]  sCount;
    logic [1:0]  sBubble;

    if_id_buffer #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc),
        .in_ready(in_ready), .flush(flush), .id_stall(id_stall), .out_valid(out_valid),
        .out_inst(out_inst), .out_pc(out_pc), .count(count), .bubble_cnt(bubble_cnt)
    );

    if_id_buffer #(.WIDTH(32), .CNT_W(2)) dutSmall (
        .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc),
        .in_ready(sInReady), .flush(flush), .id_stall(id_stall), .out_valid(sOutValid),
        .out_inst(sOutInst), .out_pc(sOutPc), .count(sCount), .bubble_cnt(sBubble)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];
    int          mCount = 0;
    int          bubBig = 0;
    int          bubSmall = 0;
    logic [31:0] nextPc = '0;
    int          popCount = 0;
    logic [31:0] lastPop = '0;

    // Checks the current outputs against the model, then applies one cycle of stimulus.
    task automatic run_cycle(input bit v, input bit stall, input bit fl);
        bit doPush, doPop;
        logic [31:0] expPc, expInst;
        expPc   = (mCount != 0) ? sb[0] : 32'h0;
        expInst = (mCount != 0) ? sb[0] + 32'h1000 : 32'h0;
        checks++;
        if (count !== 2'(mCount)) begin
            errors++; $display("FAIL count got %0d want %0d", count, mCount);
        end
        checks++;
        if (in_ready !== (mCount != 2)) begin
            errors++; $display("FAIL in_ready got %b want %b", in_ready, mCount != 2);
        end
        checks++;
        if (out_valid !== (mCount != 0)) begin
            errors++; $display("FAIL out_valid got %b want %b", out_valid, mCount != 0);
        end
        checks++;
        if (out_pc !== expPc) begin
            errors++; $display("FAIL out_pc got %h want %h", out_pc, expPc);
        end
        checks++;
        if (out_inst !== expInst) begin
            errors++; $display("FAIL out_inst got %h want %h", out_inst, expInst);
        end
        checks++;
        if (bubble_cnt !== 16'(bubBig)) begin
            errors++; $display("FAIL bubble_cnt got %0d want %0d", bubble_cnt, bubBig);
        end
        in_valid = v;
        in_pc    = nextPc;
        in_inst  = nextPc + 32'h1000;
        id_stall = stall;
        flush    = fl;
        doPush   = v && (mCount != 2) && !fl;
        doPop    = (mCount != 0) && !stall && !fl;
        @(posedge clk);
        if (mCount == 0) begin
            if (bubBig < 65535) bubBig++;
            if (bubSmall < 3) bubSmall++;
        end
        if (fl) begin
            sb.delete();
            mCount = 0;
        end else begin
            if (doPop) begin
                lastPop = sb.pop_front();
                popCount++;
                mCount--;
            end
            if (doPush) begin
                sb.push_back(nextPc);
                nextPc += 4;
                mCount++;
            end
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        clrn = 1'b0;
        in_valid = 1'b1;
        flush = 1'b0;
        id_stall = 1'b0;
        @(posedge clk);
        sb.delete();
        mCount = 0;
        bubBig = 0;
        bubSmall = 0;
        @(negedge clk);
        clrn = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_pc !== 32'h0) begin
            errors++; $display("FAIL reset_out got v=%b i=%h p=%h want 0/0/0",
                               out_valid, out_inst, out_pc);
        end
        checks++;
        if (in_ready !== 1'b1 || count !== 2'd0 || bubble_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_state got rdy=%b cnt=%0d bub=%0d want 1/0/0",
                               in_ready, count, bubble_cnt);
        end
    endtask

    task automatic test_streaming();
        apply_reset();
        nextPc = 32'h0;
        for (int i = 0; i < 8; i++) run_cycle(1'b1, 1'b0, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_stall_fill();
        apply_reset();
        nextPc = 32'h0;
        run_cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) run_cycle(1'b1, 1'b1, 1'b0);
        checks++;
        if (count !== 2'd2 || out_pc !== 32'h0) begin
            errors++; $display("FAIL stall_full got cnt=%0d pc=%h want 2/0", count, out_pc);
        end
        for (int i = 0; i < 5; i++) run_cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        apply_reset();
        nextPc = 32'h0;
        popCount = 0;
        for (int i = 0; i < 60 && popCount < 10; i++) begin
            run_cycle(nextPc < 32'd40, ((i / 2) % 2) == 1, 1'b0);
        end
        checks++;
        if (popCount != 10 || lastPop !== 32'd36) begin
            errors++; $display("FAIL wrap_order got pops=%0d last=%h want 10/24",
                               popCount, lastPop);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        nextPc = 32'h20;
        run_cycle(1'b1, 1'b1, 1'b0);
        run_cycle(1'b1, 1'b1, 1'b0);
        run_cycle(1'b1, 1'b1, 1'b1);
        checks++;
        if (count !== 2'd0 || out_valid !== 1'b0 || out_inst !== 32'h0) begin
            errors++; $display("FAIL flush_empty got cnt=%0d v=%b i=%h want 0/0/0",
                               count, out_valid, out_inst);
        end
        nextPc = 32'h100;
        run_cycle(1'b1, 1'b1, 1'b0);
        checks++;
        if (out_pc !== 32'h100) begin
            errors++; $display("FAIL flush_repush got %h want 00000100", out_pc);
        end
        run_cycle(1'b0, 1'b0, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_mid_reset();
        apply_reset();
        nextPc = 32'h40;
        run_cycle(1'b1, 1'b1, 1'b0);
        run_cycle(1'b1, 1'b1, 1'b0);
        run_cycle(1'b1, 1'b1, 1'b0);
        apply_reset();
        checks++;
        if (count !== 2'd0 || out_valid !== 1'b0 || bubble_cnt !== 16'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset got cnt=%0d v=%b bub=%0d rdy=%b want 0/0/0/1",
                               count, out_valid, bubble_cnt, in_ready);
        end
    endtask

    task automatic test_bubble();
        apply_reset();
        for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (bubble_cnt !== 16'd5) begin
            errors++; $display("FAIL bubble5 got %0d want 5", bubble_cnt);
        end
        run_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (sBubble !== 2'd3) begin
            errors++; $display("FAIL bubble_sat got %0d want 3", sBubble);
        end
        checks++;
        if (sBubble !== 2'(bubSmall)) begin
            errors++; $display("FAIL bubble_model got %0d want %0d", sBubble, bubSmall);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_streaming();
        test_stall_fill();
        test_wrap();
        test_flush();
        test_mid_reset();
        test_bubble();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
